instr_fetch_mem: RTL and testbench

INSTR_FETCH_MEM -- requirements
Module: instr_fetch_mem

---
 rtl/instr_mem_pkg.sv | 17 +
 rtl/rsp_fifo.sv | 77 +++++++
 rtl/instr_fetch_mem.sv | 139 +++++++++++++
 tb/tb_instr_fetch_mem.sv | 239 +++++++++++++++++++++++
 4 files changed

// File: rtl/instr_mem_pkg.sv
// Shared constants for the instruction fetch memory: error bit positions,
// the NOP encoding and the default parameter values.
package instr_mem_pkg;

    localparam int DEF_WORD_W = 32;
    localparam int DEF_DEPTH  = 128;
    localparam int DEF_ADDR_W = 32;
    localparam int DEF_LAT    = 1;

    localparam int ERR_W        = 2;
    localparam int ERR_MISALIGN = 0;
    localparam int ERR_RANGE    = 1;

    // Returned in place of memory data whenever a fetch is in error.
    localparam logic [DEF_WORD_W-1:0] NOP = '0;

endpackage

// File: rtl/rsp_fifo.sv
// Synchronous in-order FIFO used as the fetch response queue.
// Works for any depth, including non powers of two.
module rsp_fifo
    import instr_mem_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int DEPTH = 2,
    localparam int CNT_W = $clog2(DEPTH + 1),
    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr_i,
    input  logic             push_i,
    input  logic [WIDTH-1:0] data_i,
    input  logic             pop_i,
    output logic [WIDTH-1:0] data_o,
    output logic             empty_o,
    output logic [CNT_W-1:0] count_o
);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0] wrPtr_q, wrPtr_d;
    logic [PTR_W-1:0] rdPtr_q, rdPtr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             full;
    logic             doPush;
    logic             doPop;

    function automatic logic [PTR_W-1:0] nextPtr(input logic [PTR_W-1:0] ptr);
        return (ptr == PTR_W'(DEPTH - 1)) ? '0 : ptr + PTR_W'(1);
    endfunction

    assign full    = (count_q == CNT_W'(DEPTH));
    assign empty_o = (count_q == '0);
    assign count_o = count_q;
    assign data_o  = mem_q[rdPtr_q];
    assign doPop   = pop_i && !empty_o;
    assign doPush  = push_i && (!full || doPop);

    always_comb begin
        wrPtr_d = wrPtr_q;
        rdPtr_d = rdPtr_q;
        count_d = count_q;
        if (doPush) begin
            wrPtr_d = nextPtr(wrPtr_q);
        end
        if (doPop) begin
            rdPtr_d = nextPtr(rdPtr_q);
        end
        case ({doPush, doPop})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase
    end

    // Clear wins over any push or pop in the same cycle.
    always_ff @(posedge clk) begin
        if (rst || clr_i) begin
            wrPtr_q <= '0;
            rdPtr_q <= '0;
            count_q <= '0;
        end else begin
            wrPtr_q <= wrPtr_d;
            rdPtr_q <= rdPtr_d;
            count_q <= count_d;
        end
    end

    always_ff @(posedge clk) begin
        if (doPush) begin
            mem_q[wrPtr_q] <= data_i;
        end
    end

endmodule

// File: rtl/instr_fetch_mem.sv
// Instruction memory with a valid/ready fetch port, a loader write port and
// an in-order response queue; read latency is LAT cycles (1 or 2).
module instr_fetch_mem
    import instr_mem_pkg::*;
#(
    parameter int WORD_W = DEF_WORD_W,
    parameter int DEPTH  = DEF_DEPTH,
    parameter int ADDR_W = DEF_ADDR_W,
    parameter int LAT    = DEF_LAT,
    localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [ADDR_W-1:0] req_addr,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [WORD_W-1:0] rsp_instr,
    output logic [ADDR_W-1:0] rsp_addr,
    output logic [ERR_W-1:0]  rsp_err,
    input  logic              ld_en,
    input  logic [IDX_W-1:0]  ld_addr,
    input  logic [WORD_W-1:0] ld_data,
    input  logic              flush
);

    localparam int QDEPTH = LAT + 1;
    localparam int NSTG   = LAT - 1;
    localparam int ENT_W  = WORD_W + ADDR_W + ERR_W;
    localparam int CNT_W  = $clog2(QDEPTH + 1);

    logic [WORD_W-1:0] mem_q [DEPTH];
    logic              ldInRange;
    logic [ADDR_W-1:0] wordIdx;
    logic [ERR_W-1:0]  reqErr;
    logic [WORD_W-1:0] reqInstr;
    logic [ENT_W-1:0]  reqEnt;
    logic              accept;
    logic              pushVal;
    logic [ENT_W-1:0]  pushEnt;
    logic [CNT_W-1:0]  stgCnt;
    logic [CNT_W-1:0]  fifoCount;
    logic              fifoEmpty;
    logic [ENT_W-1:0]  fifoHead;
    logic              pop;
    logic [CNT_W:0]    outstanding;

    if (DEPTH == (1 << IDX_W)) begin : gLdFull
        assign ldInRange = 1'b1;
    end else begin : gLdPartial
        assign ldInRange = (int'(ld_addr) < DEPTH);
    end

    // Loader writes are blocked during reset but memory itself is never cleared.
    always_ff @(posedge clk) begin
        if (!rst && ld_en && ldInRange) begin
            mem_q[ld_addr] <= ld_data;
        end
    end

    // The memory read happens here and is captured on the acceptance edge,
    // so a same-edge loader write is seen only by later fetches.
    always_comb begin
        reqErr               = '0;
        wordIdx              = req_addr >> 2;
        reqErr[ERR_MISALIGN] = (req_addr[1:0] != 2'b00);
        reqErr[ERR_RANGE]    = (wordIdx >= ADDR_W'(DEPTH));
        reqInstr             = WORD_W'(NOP);
        if (reqErr == '0) begin
            reqInstr = mem_q[wordIdx[IDX_W-1:0]];
        end
    end

    assign reqEnt = {reqInstr, req_addr, reqErr};

    assign pop         = rsp_valid && rsp_ready;
    assign outstanding = (CNT_W+1)'(stgCnt) + (CNT_W+1)'(fifoCount) - (CNT_W+1)'(pop);
    assign req_ready   = !flush && (outstanding < (CNT_W+1)'(QDEPTH));
    assign accept      = req_valid && req_ready && !rst;

    // LAT-1 delay stages sit in front of the queue; with LAT=1 an accepted
    // request is written straight into the queue on its acceptance edge.
    if (NSTG == 0) begin : gNoStage
        assign pushVal = accept;
        assign pushEnt = reqEnt;
        assign stgCnt  = '0;
    end else begin : gStage
        logic [NSTG-1:0]  stgValid_q;
        logic [ENT_W-1:0] stgEnt_q [NSTG];

        always_ff @(posedge clk) begin
            if (rst || flush) begin
                stgValid_q <= '0;
            end else begin
                stgValid_q[0] <= accept;
                for (int i = 1; i < NSTG; i++) begin
                    stgValid_q[i] <= stgValid_q[i-1];
                end
            end
        end

        always_ff @(posedge clk) begin
            stgEnt_q[0] <= reqEnt;
            for (int i = 1; i < NSTG; i++) begin
                stgEnt_q[i] <= stgEnt_q[i-1];
            end
        end

        always_comb begin
            stgCnt = '0;
            for (int i = 0; i < NSTG; i++) begin
                stgCnt = stgCnt + CNT_W'(stgValid_q[i]);
            end
        end

        assign pushVal = stgValid_q[NSTG-1];
        assign pushEnt = stgEnt_q[NSTG-1];
    end

    rsp_fifo #(
        .WIDTH(ENT_W),
        .DEPTH(QDEPTH)
    ) u_rsp_fifo (
        .clk    (clk),
        .rst    (rst),
        .clr_i  (flush),
        .push_i (pushVal),
        .data_i (pushEnt),
        .pop_i  (pop),
        .data_o (fifoHead),
        .empty_o(fifoEmpty),
        .count_o(fifoCount)
    );

    assign rsp_valid                      = !fifoEmpty;
    assign {rsp_instr, rsp_addr, rsp_err} = fifoHead;

endmodule

// File: tb/tb_instr_fetch_mem.sv
// Bench for instr_fetch_mem: a LAT=1 and a LAT=2 instance share all inputs and
// are checked every cycle against a transaction-level model.
module tb_instr_fetch_mem;

    localparam int DEPTH = 12;
    localparam int NDUT  = 2;

    logic        clk       = 1'b0;
    logic        rst       = 1'b1;
    logic        req_valid = 1'b0;
    logic        rsp_ready = 1'b0;
    logic        ld_en     = 1'b0;
    logic        flush     = 1'b0;
    logic [31:0] req_addr  = '0;
    logic [31:0] ld_data   = '0;
    logic [3:0]  ld_addr   = '0;

    logic [1:0]       dReady;
    logic [1:0]       dValid;
    logic [1:0][31:0] dInstr;
    logic [1:0][31:0] dAddr;
    logic [1:0][1:0]  dErr;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    instr_fetch_mem #(.WORD_W(32), .DEPTH(DEPTH), .ADDR_W(32), .LAT(1)) dut1 (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(dReady[0]),
        .req_addr(req_addr), .rsp_valid(dValid[0]), .rsp_ready(rsp_ready),
        .rsp_instr(dInstr[0]), .rsp_addr(dAddr[0]), .rsp_err(dErr[0]),
        .ld_en(ld_en), .ld_addr(ld_addr), .ld_data(ld_data), .flush(flush)
    );

    instr_fetch_mem #(.WORD_W(32), .DEPTH(DEPTH), .ADDR_W(32), .LAT(2)) dut2 (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(dReady[1]),
        .req_addr(req_addr), .rsp_valid(dValid[1]), .rsp_ready(rsp_ready),
        .rsp_instr(dInstr[1]), .rsp_addr(dAddr[1]), .rsp_err(dErr[1]),
        .ld_en(ld_en), .ld_addr(ld_addr), .ld_data(ld_data), .flush(flush)
    );

    // Model: every accepted fetch becomes a response record that turns visible
    // LAT cycles after acceptance and leaves in order when taken.
    typedef struct {
        logic [31:0] instr;
        logic [31:0] addr;
        logic [1:0]  err;
        int          vis;
    } rsp_t;

    rsp_t        mq [NDUT][8];
    int          mcnt [NDUT];
    logic [31:0] mmem [DEPTH];
    int          cyc = 0;
    int          dutAcc [NDUT];
    bit          mv [NDUT];
    bit          mr [NDUT];

    function automatic bit expValid(input int k);
        return (mcnt[k] > 0) && (mq[k][0].vis <= cyc);
    endfunction

    function automatic bit expReady(input int k);
        int busy;
        busy = mcnt[k] - ((expValid(k) && rsp_ready) ? 1 : 0);
        return !flush && (busy < k + 2);
    endfunction

    function automatic rsp_t makeRsp(input logic [31:0] a, input int k);
        rsp_t r;
        r.addr   = a;
        r.err[0] = (a % 4) != 0;
        r.err[1] = (a / 4) >= DEPTH;
        r.instr  = (r.err != 2'b00) ? 32'h0 : mmem[a / 4];
        r.vis    = cyc + k + 1;
        return r;
    endfunction

    always @(posedge clk) begin
        for (int k = 0; k < NDUT; k++) begin
            mv[k] = expValid(k);
            mr[k] = expReady(k);
        end
        if (rst) begin
            for (int k = 0; k < NDUT; k++) mcnt[k] = 0;
        end else begin
            for (int k = 0; k < NDUT; k++) begin
                if (mv[k] && rsp_ready) begin
                    for (int i = 0; i < mcnt[k] - 1; i++) mq[k][i] = mq[k][i+1];
                    mcnt[k] = mcnt[k] - 1;
                end
                if (req_valid && mr[k]) begin
                    mq[k][mcnt[k]] = makeRsp(req_addr, k);
                    mcnt[k] = mcnt[k] + 1;
                end
                if (flush) mcnt[k] = 0;
            end
            if (ld_en && (int'(ld_addr) < DEPTH)) mmem[ld_addr] = ld_data;
        end
        cyc = cyc + 1;
    end

    task automatic checkOutput(input string name, input int k,
                               input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s dut%0d: got 0x%0h, expected 0x%0h (cycle %0d)",
                     name, k, act, exp, cyc);
        end
    endtask

    // Every-cycle comparison against the model, away from the active edge.
    always @(negedge clk) begin
        if (!rst) begin
            for (int k = 0; k < NDUT; k++) begin
                checkOutput("req_ready", k, 32'(dReady[k]), 32'(expReady(k)));
                checkOutput("rsp_valid", k, 32'(dValid[k]), 32'(expValid(k)));
                if (expValid(k)) begin
                    checkOutput("rsp_instr", k, dInstr[k], mq[k][0].instr);
                    checkOutput("rsp_addr", k, dAddr[k], mq[k][0].addr);
                    checkOutput("rsp_err", k, 32'(dErr[k]), 32'(mq[k][0].err));
                end
                if (req_valid && dReady[k]) dutAcc[k]++;
            end
        end
    end

    task automatic applyStimulus(input logic rv, input logic [31:0] a, input logic rr,
                                 input logic le, input logic [3:0] la, input logic [31:0] ld,
                                 input logic fl, input logic rs);
        req_valid = rv;
        req_addr  = a;
        rsp_ready = rr;
        ld_en     = le;
        ld_addr   = la;
        ld_data   = ld;
        flush     = fl;
        rst       = rs;
        @(posedge clk);
        #1;
    endtask

    logic [31:0] exp41 [4] = '{32'h11, 32'h22, 32'h33, 32'h44};
    int          acc0, acc1, sel;
    logic [31:0] ra;

    initial begin
        repeat (3) applyStimulus(0, 0, 0, 0, 0, 0, 0, 1);
        rst = 1'b0;
        #1;
        for (int k = 0; k < NDUT; k++) begin
            checkOutput("reset_req_ready", k, 32'(dReady[k]), 32'd1);
            checkOutput("reset_rsp_valid", k, 32'(dValid[k]), 32'd0);
        end

        // Streamed fetches of words 0..3 at one per cycle.
        for (int i = 0; i < 4; i++) applyStimulus(0, 0, 0, 1, 4'(i), exp41[i], 0, 0);
        for (int i = 0; i < 4; i++) begin
            applyStimulus(1, 32'(4 * i), 1, 0, 0, 0, 0, 0);
            checkOutput("stream_valid", 0, 32'(dValid[0]), 32'd1);
            checkOutput("stream_instr", 0, dInstr[0], exp41[i]);
            checkOutput("stream_err", 0, 32'(dErr[0]), 32'd0);
        end
        repeat (3) applyStimulus(0, 0, 1, 0, 0, 0, 0, 0);

        // Misaligned and out-of-range fetches.
        applyStimulus(1, 32'h6, 1, 0, 0, 0, 0, 0);
        checkOutput("misalign_err", 0, 32'(dErr[0]), 32'd1);
        checkOutput("misalign_instr", 0, dInstr[0], 32'd0);
        checkOutput("misalign_addr", 0, dAddr[0], 32'h6);
        applyStimulus(1, 32'(4 * DEPTH), 1, 0, 0, 0, 0, 0);
        checkOutput("range_err", 0, 32'(dErr[0]), 32'd2);
        checkOutput("range_instr", 0, dInstr[0], 32'd0);
        repeat (3) applyStimulus(0, 0, 1, 0, 0, 0, 0, 0);

        // Read-before-write against a same-cycle loader write.
        applyStimulus(0, 0, 1, 1, 4'd2, 32'hAA, 0, 0);
        applyStimulus(1, 32'h8, 1, 1, 4'd2, 32'hBB, 0, 0);
        checkOutput("rbw_old", 0, dInstr[0], 32'hAA);
        applyStimulus(1, 32'h8, 1, 0, 0, 0, 0, 0);
        checkOutput("rbw_new", 0, dInstr[0], 32'hBB);
        repeat (3) applyStimulus(0, 0, 1, 0, 0, 0, 0, 0);

        // Back-pressure: six cycles of requests with the consumer stalled.
        acc0 = dutAcc[0];
        acc1 = dutAcc[1];
        for (int i = 0; i < 6; i++) applyStimulus(1, 32'(4 * (i % 3)), 0, 0, 0, 0, 0, 0);
        checkOutput("stall_accepts", 0, 32'(dutAcc[0] - acc0), 32'd2);
        checkOutput("stall_accepts", 1, 32'(dutAcc[1] - acc1), 32'd3);
        checkOutput("stall_ready", 1, 32'(dReady[1]), 32'd0);
        checkOutput("drain_addr0", 1, dAddr[1], 32'h0);
        for (int j = 1; j < 3; j++) begin
            applyStimulus(0, 0, 1, 0, 0, 0, 0, 0);
            checkOutput("drain_addr", 1, dAddr[1], 32'(4 * j));
        end
        repeat (3) applyStimulus(0, 0, 1, 0, 0, 0, 0, 0);

        // Flush with two responses queued.
        repeat (2) applyStimulus(1, 32'h4, 0, 0, 0, 0, 0, 0);
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 0);
        applyStimulus(0, 0, 0, 0, 0, 0, 1, 0);
        for (int k = 0; k < NDUT; k++) checkOutput("flush_valid", k, 32'(dValid[k]), 32'd0);
        repeat (4) applyStimulus(0, 0, 1, 0, 0, 0, 0, 0);
        for (int k = 0; k < NDUT; k++) checkOutput("flush_stale", k, 32'(dValid[k]), 32'd0);

        // Reset with two responses queued.
        repeat (2) applyStimulus(1, 32'h0, 0, 0, 0, 0, 0, 0);
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 0);
        applyStimulus(0, 0, 0, 1, 4'd1, 32'hDEAD, 1, 1);
        for (int k = 0; k < NDUT; k++) checkOutput("rst_valid", k, 32'(dValid[k]), 32'd0);
        rst = 1'b0;
        ld_en = 1'b0;
        flush = 1'b0;
        #1;
        for (int k = 0; k < NDUT; k++) checkOutput("rst_ready", k, 32'(dReady[k]), 32'd1);
        applyStimulus(1, 32'h4, 1, 0, 0, 0, 0, 0);
        checkOutput("rst_keeps_mem", 0, dInstr[0], 32'h22);
        repeat (4) applyStimulus(0, 0, 1, 0, 0, 0, 0, 0);

        // Fill the whole memory, then randomized traffic.
        for (int i = 0; i < DEPTH; i++) applyStimulus(0, 0, 1, 1, 4'(i), $urandom, 0, 0);
        for (int n = 0; n < 3000; n++) begin
            sel = $urandom_range(0, 99);
            if (sel < 75) ra = 32'(4 * $urandom_range(0, DEPTH - 1));
            else if (sel < 88) ra = 32'(4 * $urandom_range(0, DEPTH - 1) + $urandom_range(1, 3));
            else ra = 32'($urandom_range(4 * DEPTH, 4 * DEPTH + 200));
            applyStimulus($urandom_range(0, 99) < 70, ra, $urandom_range(0, 99) < 60,
                          $urandom_range(0, 99) < 20, 4'($urandom_range(0, 15)), $urandom,
                          $urandom_range(0, 99) < 3, $urandom_range(0, 199) == 0);
        end
        repeat (6) applyStimulus(0, 0, 1, 0, 0, 0, 0, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
